// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared types for the APB command master and its command queue.
//   apb_state_t : transfer FSM states (IDLE, SETUP, ACCESS)
//   apb_cmd_t   : one queued command {write, addr, wdata}
//   APB_AW/DW   : APB address and data widths
// ---------------------------------------------------------------------------
package apb_pkg;

   localparam int APB_AW = 32;
   localparam int APB_DW = 32;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } apb_state_t;

   typedef struct packed {
      logic              write;
      logic [APB_AW-1:0] addr;
      logic [APB_DW-1:0] wdata;
   } apb_cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// ---------------------------------------------------------------------------
// cmd_fifo
// Synchronous FIFO of apb_cmd_t used as the command queue of the APB master.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (flushes the queue)
//   push        : write push_data this cycle (ignored when full)
//   push_data   : command to enqueue
//   pop         : drop the head entry this cycle (ignored when empty)
//   head        : current head entry, valid whenever empty is low
//   full, empty : occupancy flags, derived from the registered count
//   count       : number of stored entries
// ---------------------------------------------------------------------------
module cmd_fifo
   import apb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  apb_cmd_t               push_data,
   input  logic                   pop,
   output apb_cmd_t               head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);

   apb_cmd_t        mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   // A push is refused while full, even when a pop frees a slot in the same
   // cycle, so cmd_ready depends only on registered state.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign full  = (count == ($clog2(DEPTH)+1)'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   // Storage array needs no reset: entries are only read once counted.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (!do_push && do_pop) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/apb_cmd_master.sv
// ---------------------------------------------------------------------------
// apb_cmd_master
// APB initiator fed by a queued command stream. Write/read commands arrive
// over valid/ready, run as fixed-length APB transfers (1 SETUP cycle plus
// ACCESS_CYCLES ACCESS cycles, no pready), and read data returns through a
// single-entry response slot over valid/ready.
// Ports:
//   clk, reset                       : clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/wdata : command input handshake and payload
//   rsp_valid/ready/rdata/addr       : read response handshake and payload
//   psel/penable/paddr/pwrite/pwdata : APB request outputs (registered)
//   prdata                           : APB read data from the responder
//   busy                             : queue non-empty or transfer in flight
// ---------------------------------------------------------------------------
module apb_cmd_master
   import apb_pkg::*;
#(
   parameter int FIFO_DEPTH    = 4,
   parameter int ACCESS_CYCLES = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [APB_AW-1:0] cmd_addr,
   input  logic [APB_DW-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [APB_DW-1:0] rsp_rdata,
   output logic [APB_AW-1:0] rsp_addr,
   output logic              psel,
   output logic              penable,
   output logic [APB_AW-1:0] paddr,
   output logic              pwrite,
   output logic [APB_DW-1:0] pwdata,
   input  logic [APB_DW-1:0] prdata,
   output logic              busy
);

   localparam int ACW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

   apb_state_t                  state;
   apb_cmd_t                    push_cmd;
   apb_cmd_t                    head;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic                        pop;
   logic [ACW-1:0]              acc_cnt;
   logic                        last_access;
   logic                        start_ok;
   logic                        chain_ok;

   assign push_cmd = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};

   cmd_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_cmd_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (cmd_valid && cmd_ready),
      .push_data (push_cmd),
      .pop       (pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign cmd_ready   = !fifo_full;
   assign pop         = (state == SETUP);
   assign last_access = (state == ACCESS) && (acc_cnt == '0);
   assign busy        = (fifo_count != '0) || (state != IDLE);

   // A queued read may only start while the response slot is empty; writes
   // can always go, but still only from the head so order is preserved.
   assign start_ok = !fifo_empty && (head.write || !rsp_valid);

   // Chaining straight out of ACCESS: a read finishing now fills the slot on
   // the next cycle, so a following read must not be launched behind it.
   assign chain_ok = !fifo_empty && (head.write || (!rsp_valid && pwrite));

   // Transfer FSM with registered APB outputs and the response slot.
   // The next command's address/data are loaded on entry to SETUP so paddr
   // is already valid while psel rises; the queue pops during SETUP.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         psel      <= 1'b0;
         penable   <= 1'b0;
         pwrite    <= 1'b0;
         paddr     <= '0;
         pwdata    <= '0;
         acc_cnt   <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_addr  <= '0;
      end else begin
         if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               psel    <= 1'b0;
               penable <= 1'b0;
               if (start_ok) begin
                  state  <= SETUP;
                  psel   <= 1'b1;
                  paddr  <= head.addr;
                  pwrite <= head.write;
                  pwdata <= head.wdata;
               end
            end

            SETUP: begin
               state   <= ACCESS;
               penable <= 1'b1;
               acc_cnt <= ACW'(ACCESS_CYCLES - 1);
            end

            ACCESS: begin
               if (!last_access) begin
                  acc_cnt <= acc_cnt - 1'b1;
               end else begin
                  // The slot is guaranteed empty here, so a capture never
                  // collides with a consumer handshake.
                  if (!pwrite) begin
                     rsp_valid <= 1'b1;
                     rsp_rdata <= prdata;
                     rsp_addr  <= paddr;
                  end
                  penable <= 1'b0;
                  if (chain_ok) begin
                     state  <= SETUP;
                     paddr  <= head.addr;
                     pwrite <= head.write;
                     pwdata <= head.wdata;
                  end else begin
                     state <= IDLE;
                     psel  <= 1'b0;
                  end
               end
            end

            default: begin
               state   <= IDLE;
               psel    <= 1'b0;
               penable <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_apb_cmd_master
// Self-checking bench for apb_cmd_master. One instance with ACCESS_CYCLES=1
// covers latency, back-to-back, response backpressure, mid-transfer reset and
// a randomized run against a queue-based model; a second instance with
// ACCESS_CYCLES=3 covers the stretched ACCESS phase.
// ---------------------------------------------------------------------------
module tb_apb_cmd_master;
   import apb_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b1;

   logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
   logic [31:0] cmd_addr = '0, cmd_wdata = '0;
   logic        cmd_ready, rsp_valid, psel, penable, pwrite, busy;
   logic [31:0] rsp_rdata, rsp_addr, paddr, pwdata, prdata;

   logic        d3_cmd_valid = 1'b0, d3_cmd_write = 1'b0, d3_rsp_ready = 1'b0;
   logic [31:0] d3_cmd_addr = '0, d3_cmd_wdata = '0, d3_prdata = '0;
   logic        d3_cmd_ready, d3_rsp_valid, d3_psel, d3_penable, d3_pwrite, d3_busy;
   logic [31:0] d3_rsp_rdata, d3_rsp_addr, d3_paddr, d3_pwdata;

   int tests_run    = 0;
   int tests_failed = 0;
   int proto_err    = 0;

   apb_cmd_t    xfer_q[$];
   apb_cmd_t    exp_x[$];
   logic [63:0] rsp_q[$];
   logic [63:0] exp_r[$];

   logic        use_func   = 1'b0;
   logic [31:0] prdata_var = '0;

   // Responder model: read data is a fixed function of the address.
   function automatic logic [31:0] rd_func(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A5A_3C3C;
   endfunction

   assign prdata = use_func ? rd_func(paddr) : prdata_var;

   apb_cmd_master #(.FIFO_DEPTH(4), .ACCESS_CYCLES(1)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_addr(rsp_addr),
      .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
      .prdata(prdata), .busy(busy)
   );

   apb_cmd_master #(.FIFO_DEPTH(4), .ACCESS_CYCLES(3)) dut3 (
      .clk(clk), .reset(reset),
      .cmd_valid(d3_cmd_valid), .cmd_ready(d3_cmd_ready), .cmd_write(d3_cmd_write),
      .cmd_addr(d3_cmd_addr), .cmd_wdata(d3_cmd_wdata),
      .rsp_valid(d3_rsp_valid), .rsp_ready(d3_rsp_ready), .rsp_rdata(d3_rsp_rdata), .rsp_addr(d3_rsp_addr),
      .psel(d3_psel), .penable(d3_penable), .paddr(d3_paddr), .pwrite(d3_pwrite), .pwdata(d3_pwdata),
      .prdata(d3_prdata), .busy(d3_busy)
   );

   // Bus monitor: logs completed transfers and consumed responses, and
   // counts protocol violations (penable without psel, read vs full slot).
   always @(negedge clk) begin
      if (!reset) begin
         if (psel && penable) xfer_q.push_back('{write: pwrite, addr: paddr, wdata: pwdata});
         if (rsp_valid && rsp_ready) rsp_q.push_back({rsp_addr, rsp_rdata});
         if (penable && !psel) proto_err++;
         if (psel && !pwrite && rsp_valid) proto_err++;
      end
   end

   // Advance one cycle and settle just after the active edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) step();
      tests_run++; if (psel !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_psel: got %b want 0", psel); end
      tests_run++; if (penable !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_penable: got %b want 0", penable); end
      tests_run++; if (pwrite !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_pwrite: got %b want 0", pwrite); end
      tests_run++; if (paddr !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_paddr: got %h want 0", paddr); end
      tests_run++; if (pwdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_pwdata: got %h want 0", pwdata); end
      tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
      tests_run++; if ({rsp_rdata, rsp_addr} !== 64'h0) begin tests_failed++; $display("[TB] FAIL reset_rsp_data: got %h want 0", {rsp_rdata, rsp_addr}); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
      tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
      reset = 1'b0;
      step();
   endtask

   task automatic test_single_write();
      use_func  = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'hDEADBEEF;
      tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL wr_cmd_ready: got %b want 1", cmd_ready); end
      step(); cmd_valid = 1'b0;                                   // T+1
      tests_run++; if (psel !== 1'b0) begin tests_failed++; $display("[TB] FAIL wr_t1_psel: got %b want 0", psel); end
      step();                                                     // T+2
      tests_run++; if ({psel, penable} !== 2'b10) begin tests_failed++; $display("[TB] FAIL wr_setup: got psel,penable=%b want 10", {psel, penable}); end
      step();                                                     // T+3
      tests_run++; if ({psel, penable, pwrite} !== 3'b111) begin tests_failed++; $display("[TB] FAIL wr_access_ctl: got %b want 111", {psel, penable, pwrite}); end
      tests_run++; if (paddr !== 32'h10) begin tests_failed++; $display("[TB] FAIL wr_paddr: got %h want 00000010", paddr); end
      tests_run++; if (pwdata !== 32'hDEADBEEF) begin tests_failed++; $display("[TB] FAIL wr_pwdata: got %h want deadbeef", pwdata); end
      step();                                                     // T+4
      tests_run++; if ({psel, penable, rsp_valid, busy} !== 4'b0000) begin tests_failed++; $display("[TB] FAIL wr_done: got psel,penable,rsp_valid,busy=%b want 0000", {psel, penable, rsp_valid, busy}); end
   endtask

   task automatic test_single_read();
      use_func   = 1'b0;
      prdata_var = 32'h12345678;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h24; cmd_wdata = 32'h0;
      step(); cmd_valid = 1'b0;                                   // T+1
      step();                                                     // T+2
      step();                                                     // T+3
      tests_run++; if ({psel, penable, pwrite, rsp_valid} !== 4'b1100) begin tests_failed++; $display("[TB] FAIL rd_access: got psel,penable,pwrite,rsp_valid=%b want 1100", {psel, penable, pwrite, rsp_valid}); end
      step();                                                     // T+4
      tests_run++; if (rsp_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL rd_rsp_valid: got %b want 1", rsp_valid); end
      tests_run++; if (rsp_rdata !== 32'h12345678) begin tests_failed++; $display("[TB] FAIL rd_rsp_rdata: got %h want 12345678", rsp_rdata); end
      tests_run++; if (rsp_addr !== 32'h24) begin tests_failed++; $display("[TB] FAIL rd_rsp_addr: got %h want 00000024", rsp_addr); end
      step();                                                     // T+5, still held
      tests_run++; if (rsp_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL rd_rsp_hold: got %b want 1", rsp_valid); end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rd_rsp_clear: got %b want 0", rsp_valid); end
   endtask

   task automatic test_back_to_back();
      int          k = 0;
      int          lows[$];
      logic        ps [18];
      logic        pe [18];
      logic [31:0] wd [7];
      use_func = 1'b1;
      xfer_q.delete();
      for (int i = 0; i < 7; i++) wd[i] = $urandom;
      for (int c = 0; c < 18; c++) begin
         if (k < 7) begin
            cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h100 + 32'(4 * k); cmd_wdata = wd[k];
            if (!cmd_ready) lows.push_back(c);
            else k++;
         end else begin
            cmd_valid = 1'b0;
         end
         ps[c] = psel;
         pe[c] = penable;
         step();
      end
      cmd_valid = 1'b0;
      tests_run++; if (k !== 7) begin tests_failed++; $display("[TB] FAIL b2b_accepted: got %0d want 7", k); end
      tests_run++; if (lows.size() !== 1 || lows[0] !== 6) begin tests_failed++; $display("[TB] FAIL b2b_full_window: got %0d low cycles first=%0d want 1 at 6", lows.size(), (lows.size() > 0) ? lows[0] : -1); end
      for (int c = 0; c < 18; c++) begin
         tests_run++;
         if (ps[c] !== (c >= 2 && c <= 15) || pe[c] !== (c >= 2 && c <= 15 && (c % 2) == 1)) begin
            tests_failed++; $display("[TB] FAIL b2b_cycle%0d: got psel,penable=%b%b want %b%b", c, ps[c], pe[c], (c >= 2 && c <= 15), (c >= 2 && c <= 15 && (c % 2) == 1));
         end
      end
      tests_run++; if (xfer_q.size() !== 7) begin tests_failed++; $display("[TB] FAIL b2b_xfer_count: got %0d want 7", xfer_q.size()); end
      for (int i = 0; i < 7 && i < xfer_q.size(); i++) begin
         tests_run++;
         if (xfer_q[i].addr !== 32'h100 + 32'(4 * i) || xfer_q[i].wdata !== wd[i] || xfer_q[i].write !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL b2b_xfer%0d: got %h/%h want %h/%h", i, xfer_q[i].addr, xfer_q[i].wdata, 32'h100 + 32'(4 * i), wd[i]);
         end
      end
   endtask

   task automatic test_rsp_backpressure();
      logic ps [16];
      logic rv [16];
      use_func  = 1'b1;
      rsp_ready = 1'b0;
      for (int c = 0; c < 16; c++) begin
         cmd_valid = (c < 3);
         cmd_write = (c == 2);
         cmd_addr  = 32'h200 + 32'(4 * c);
         cmd_wdata = 32'hA0A0_0000 + 32'(c);
         rsp_ready = (c == 9);
         ps[c] = psel;
         rv[c] = rsp_valid;
         if (c == 8) begin
            tests_run++; if ({rsp_addr, rsp_rdata} !== {32'h200, rd_func(32'h200)}) begin tests_failed++; $display("[TB] FAIL bp_rsp1: got %h want %h", {rsp_addr, rsp_rdata}, {32'h200, rd_func(32'h200)}); end
         end
         if (c == 12) begin
            tests_run++; if ({penable, pwrite, paddr} !== {1'b1, 1'b0, 32'h204}) begin tests_failed++; $display("[TB] FAIL bp_read2: got en,wr,addr=%b,%b,%h want 1,0,00000204", penable, pwrite, paddr); end
         end
         if (c == 14) begin
            tests_run++; if ({penable, pwrite, paddr, pwdata} !== {1'b1, 1'b1, 32'h208, 32'hA0A0_0002}) begin tests_failed++; $display("[TB] FAIL bp_write: got en,wr,addr,data=%b,%b,%h,%h want 1,1,00000208,a0a00002", penable, pwrite, paddr, pwdata); end
         end
         if (c == 15) begin
            tests_run++; if ({rsp_addr, rsp_rdata} !== {32'h204, rd_func(32'h204)}) begin tests_failed++; $display("[TB] FAIL bp_rsp2: got %h want %h", {rsp_addr, rsp_rdata}, {32'h204, rd_func(32'h204)}); end
         end
         step();
      end
      cmd_valid = 1'b0;
      for (int c = 0; c < 16; c++) begin
         tests_run++;
         if (ps[c] !== ((c >= 2 && c <= 3) || (c >= 11 && c <= 14)) || rv[c] !== ((c >= 4 && c <= 9) || c >= 13)) begin
            tests_failed++; $display("[TB] FAIL bp_cycle%0d: got psel,rsp_valid=%b%b want %b%b", c, ps[c], rv[c], ((c >= 2 && c <= 3) || (c >= 11 && c <= 14)), ((c >= 4 && c <= 9) || c >= 13));
         end
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
   endtask

   task automatic test_access3();
      logic        pe [8];
      logic        ps [8];
      logic [31:0] pa [8];
      logic [31:0] final_data = 32'hCAFEF00D;
      for (int c = 0; c < 8; c++) begin
         d3_cmd_valid = (c == 0); d3_cmd_write = 1'b0; d3_cmd_addr = 32'h300; d3_cmd_wdata = 32'h0;
         d3_prdata = (c == 5) ? final_data : (final_data ^ ($urandom | 32'h1));
         pe[c] = d3_penable;
         ps[c] = d3_psel;
         pa[c] = d3_paddr;
         if (c == 5) begin
            tests_run++; if (d3_rsp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL ac3_rsp_early: got %b want 0", d3_rsp_valid); end
         end
         if (c == 6) begin
            tests_run++; if (d3_rsp_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL ac3_rsp_valid: got %b want 1", d3_rsp_valid); end
            tests_run++; if ({d3_rsp_addr, d3_rsp_rdata} !== {32'h300, final_data}) begin tests_failed++; $display("[TB] FAIL ac3_rsp_data: got %h want %h", {d3_rsp_addr, d3_rsp_rdata}, {32'h300, final_data}); end
         end
         step();
      end
      for (int c = 0; c < 8; c++) begin
         tests_run++;
         if (pe[c] !== (c >= 3 && c <= 5) || ps[c] !== (c >= 2 && c <= 5)) begin
            tests_failed++; $display("[TB] FAIL ac3_cycle%0d: got psel,penable=%b%b want %b%b", c, ps[c], pe[c], (c >= 2 && c <= 5), (c >= 3 && c <= 5));
         end
      end
      tests_run++; if (pa[3] !== 32'h300 || pa[4] !== 32'h300 || pa[5] !== 32'h300) begin tests_failed++; $display("[TB] FAIL ac3_paddr_stable: got %h %h %h want 00000300", pa[3], pa[4], pa[5]); end
      d3_rsp_ready = 1'b1;
      step();
      d3_rsp_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      use_func  = 1'b1;
      rsp_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         cmd_valid = 1'b1; cmd_write = (c != 0); cmd_addr = 32'h400 + 32'(4 * c); cmd_wdata = $urandom;
         step();
      end
      cmd_valid = 1'b0;                                           // c3: ACCESS of the read
      tests_run++; if ({psel, penable, pwrite} !== 3'b110) begin tests_failed++; $display("[TB] FAIL rm_in_access: got psel,penable,pwrite=%b want 110", {psel, penable, pwrite}); end
      reset = 1'b1;
      step();                                                     // c4
      reset = 1'b0;
      tests_run++; if ({psel, penable, busy, cmd_ready, rsp_valid} !== 5'b00010) begin tests_failed++; $display("[TB] FAIL rm_after_reset: got psel,penable,busy,cmd_ready,rsp_valid=%b want 00010", {psel, penable, busy, cmd_ready, rsp_valid}); end
      for (int c = 0; c < 5; c++) begin
         step();
         tests_run++; if ({psel, rsp_valid, busy} !== 3'b000) begin tests_failed++; $display("[TB] FAIL rm_flushed%0d: got psel,rsp_valid,busy=%b want 000", c, {psel, rsp_valid, busy}); end
      end
   endtask

   task automatic test_random();
      int       sent = 0;
      int       c;
      bit       acc;
      int       bad = 0;
      apb_cmd_t cur = '0;
      use_func = 1'b1;
      xfer_q.delete(); rsp_q.delete(); exp_x.delete(); exp_r.delete();
      proto_err = 0;
      for (c = 0; c < 4000; c++) begin
         if (sent == 40 && !cmd_valid && !busy && !rsp_valid) break;
         if (!cmd_valid && sent < 40 && $urandom_range(0, 99) < 70) begin
            cur.write = 1'($urandom_range(0, 1));
            cur.addr  = {16'h0, 16'($urandom) & 16'hFFFC};
            cur.wdata = $urandom;
            cmd_valid = 1'b1; cmd_write = cur.write; cmd_addr = cur.addr; cmd_wdata = cur.wdata;
         end
         rsp_ready = 1'($urandom_range(0, 1));
         acc = cmd_valid && cmd_ready;
         if (acc) begin
            exp_x.push_back(cur);
            if (!cur.write) exp_r.push_back({cur.addr, rd_func(cur.addr)});
            sent++;
         end
         step();
         if (acc) cmd_valid = 1'b0;
      end
      rsp_ready = 1'b0;
      tests_run++; if (c >= 4000) begin tests_failed++; $display("[TB] FAIL rnd_timeout: got %0d sent, busy=%b want drained", sent, busy); end
      tests_run++; if (xfer_q.size() !== exp_x.size()) begin tests_failed++; $display("[TB] FAIL rnd_xfer_count: got %0d want %0d", xfer_q.size(), exp_x.size()); end
      for (int i = 0; i < exp_x.size() && i < xfer_q.size(); i++) begin
         if (xfer_q[i].write !== exp_x[i].write || xfer_q[i].addr !== exp_x[i].addr ||
             (exp_x[i].write && xfer_q[i].wdata !== exp_x[i].wdata)) bad++;
      end
      tests_run++; if (bad !== 0) begin tests_failed++; $display("[TB] FAIL rnd_xfer_order: got %0d wrong transfers want 0", bad); end
      tests_run++; if (rsp_q !== exp_r) begin tests_failed++; $display("[TB] FAIL rnd_responses: got %0d responses want %0d in order", rsp_q.size(), exp_r.size()); end
      tests_run++; if (proto_err !== 0) begin tests_failed++; $display("[TB] FAIL rnd_protocol: got %0d violations want 0", proto_err); end
   endtask

   initial begin
      #1;
      test_reset();
      test_single_write();
      test_single_read();
      test_back_to_back();
      test_rsp_backpressure();
      test_access3();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
